// File: rtl/ncl_dr_adder_stage_if.sv
// Dual-rail operand/result bundle with its completion handshake.
// master drives operands and ack_in; slave (the adder stage) drives results.
interface ncl_dr_adder_stage_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [1:0]         cin;
  logic               sub;
  logic               ack_in;
  logic [2*WIDTH-1:0] sum;
  logic [1:0]         cout;
  logic               ack_out;
  logic               err;
  logic [CNT_W-1:0]   wave_cnt;

  modport master (
    output a, b, cin, sub, ack_in,
    input  sum, cout, ack_out, err, wave_cnt
  );

  modport slave (
    input  a, b, cin, sub, ack_in,
    output sum, cout, ack_out, err, wave_cnt
  );
endinterface

// File: rtl/ncl_dr_adder_stage.sv
// Clocked dual-rail ripple add/sub stage with DATA/NULL wavefront handshake; 1-cycle latency.
// Holds its wavefront until ack_in requests the next one and inputs are complete.
module ncl_dr_adder_stage #(
  parameter int WIDTH  = 4,
  parameter int SUB_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 init_n,
  ncl_dr_adder_stage_if.slave  bus
);

  typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] sum_q;
  logic [1:0]         cout_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   a_t;
  logic [WIDTH-1:0]   b_t;
  logic               in_data;
  logic               in_null;
  logic               illegal;
  logic               s;
  logic [WIDTH:0]     res;
  logic [2*WIDTH-1:0] sum_enc;

  // Completeness covers cin as well as every operand digit.
  always_comb begin
    a_t     = '0;
    b_t     = '0;
    in_data = ^bus.cin;
    illegal = &bus.cin;
    for (int i = 0; i < WIDTH; i++) begin
      a_t[i]  = bus.a[2*i+1];
      b_t[i]  = bus.b[2*i+1];
      in_data = in_data & (^bus.a[2*i +: 2]) & (^bus.b[2*i +: 2]);
      illegal = illegal | (&bus.a[2*i +: 2]) | (&bus.b[2*i +: 2]);
    end
  end

  assign in_null = ~(|bus.a | |bus.b | |bus.cin);
  assign s       = bus.sub & (SUB_EN != 0);
  assign res     = {1'b0, a_t} + {1'b0, b_t ^ {WIDTH{s}}} + {{WIDTH{1'b0}}, bus.cin[1] ^ s};

  always_comb begin
    sum_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_enc[2*i+1] = res[i];
      sum_enc[2*i]   = ~res[i];
    end
  end

  // Once err is set the whole stage freezes until init_n.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state  <= S_NULL;
      sum_q  <= '0;
      cout_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (!err_q) begin
      if (illegal) begin
        err_q <= 1'b1;
      end else begin
        case (state)
          S_NULL: if (in_data && !bus.ack_in) begin
            state  <= S_DATA;
            sum_q  <= sum_enc;
            cout_q <= {res[WIDTH], ~res[WIDTH]};
            cnt_q  <= cnt_q + CNT_W'(1);
          end
          S_DATA: if (in_null && bus.ack_in) begin
            state  <= S_NULL;
            sum_q  <= '0;
            cout_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ack_out  = (state == S_DATA);
  assign bus.err      = err_q;
  assign bus.wave_cnt = cnt_q;

endmodule

// File: tb/tb_ncl_dr_adder_stage.sv
// Bench for ncl_dr_adder_stage: directed wavefronts plus randomized traffic against an arithmetic model.
module tb_ncl_dr_adder_stage;

  logic       clk = 1'b0;
  logic       init_n;
  logic [7:0] a_d;
  logic [7:0] b_d;
  logic [1:0] cin_d;
  logic       sub_d;
  logic       ack_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ncl_dr_adder_stage_if #(.WIDTH(4), .CNT_W(8)) bus8 ();
  ncl_dr_adder_stage_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus8.a = a_d;   assign bus8.b = b_d;   assign bus8.cin = cin_d;
  assign bus8.sub = sub_d; assign bus8.ack_in = ack_d;
  assign bus2.a = a_d;   assign bus2.b = b_d;   assign bus2.cin = cin_d;
  assign bus2.sub = sub_d; assign bus2.ack_in = ack_d;

  ncl_dr_adder_stage #(.WIDTH(4), .SUB_EN(1), .CNT_W(8)) dut (
    .clk(clk), .init_n(init_n), .bus(bus8)
  );
  ncl_dr_adder_stage #(.WIDTH(4), .SUB_EN(1), .CNT_W(2)) dut_w (
    .clk(clk), .init_n(init_n), .bus(bus2)
  );

  function automatic logic [7:0] enc(input int v);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[2*i+1] = v[i];
      e[2*i]   = ~v[i];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int av, input int bv, input bit c, input bit sv);
    a_d   = enc(av);
    b_d   = enc(bv);
    cin_d = c ? 2'b10 : 2'b01;
    sub_d = sv;
  endtask

  task automatic drive_null();
    a_d   = '0;
    b_d   = '0;
    cin_d = '0;
  endtask

  // Behavioural model: classify digits, do the arithmetic as integers.
  logic        m_state = 1'b0;
  logic [7:0]  m_sum   = '0;
  logic [1:0]  m_cout  = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_cnt   = '0;
  int          mA, mB, mC, mr;
  bit          m_ok, m_bad, m_nul;

  always @(posedge clk) begin
    if (!init_n) begin
      m_state <= 1'b0; m_sum <= '0; m_cout <= '0; m_err <= 1'b0; m_cnt <= '0;
    end else if (!m_err) begin
      m_ok  = (cin_d == 2'b01) || (cin_d == 2'b10);
      m_bad = (cin_d == 2'b11);
      mA = 0; mB = 0;
      for (int i = 0; i < 4; i++) begin
        if (!(a_d[2*i +: 2] inside {2'b01, 2'b10})) m_ok = 1'b0;
        if (!(b_d[2*i +: 2] inside {2'b01, 2'b10})) m_ok = 1'b0;
        if (a_d[2*i +: 2] == 2'b11 || b_d[2*i +: 2] == 2'b11) m_bad = 1'b1;
        mA = mA + (a_d[2*i+1] ? (1 << i) : 0);
        mB = mB + (b_d[2*i+1] ? (1 << i) : 0);
      end
      m_nul = (a_d == 8'h00) && (b_d == 8'h00) && (cin_d == 2'b00);
      mC = cin_d[1] ? 1 : 0;
      if (m_bad) begin
        m_err <= 1'b1;
      end else if (!m_state && m_ok && !ack_d) begin
        mr = sub_d ? (mA - mB - mC + 16) : (mA + mB + mC);
        m_sum   <= enc(mr % 16);
        m_cout  <= (mr >= 16) ? 2'b10 : 2'b01;
        m_state <= 1'b1;
        m_cnt   <= m_cnt + 1;
      end else if (m_state && m_nul && ack_d) begin
        m_state <= 1'b0; m_sum <= '0; m_cout <= '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_w8", {bus8.sum, bus8.cout, bus8.ack_out, bus8.err, bus8.wave_cnt},
                    {m_sum, m_cout, m_state, m_err, m_cnt[7:0]});
    chk("model_w2", {bus2.sum, bus2.cout, bus2.ack_out, bus2.err, bus2.wave_cnt},
                    {m_sum, m_cout, m_state, m_err, m_cnt[1:0]});
  end

  logic [1:0] wrap_exp [2] = '{2'd0, 2'd1};
  int         r;

  initial begin
    init_n = 1'b0; ack_d = 1'b0;
    drive(5, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_sum", bus8.sum, 8'h00);
    chk("rst_cout", bus8.cout, 2'b00);
    chk("rst_ack", bus8.ack_out, 1'b0);
    chk("rst_err", bus8.err, 1'b0);
    chk("rst_cnt", bus8.wave_cnt, 8'd0);

    init_n = 1'b1;
    @(negedge clk);
    chk("add_sum", bus8.sum, 8'b10010101);
    chk("add_cout", bus8.cout, 2'b01);
    chk("add_ack", bus8.ack_out, 1'b1);
    chk("add_cnt", bus8.wave_cnt, 8'd1);

    drive(1, 1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_sum", bus8.sum, 8'b10010101);

    ack_d = 1'b1; a_d = '0; b_d = '0; cin_d = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("cin_complete_ack", bus8.ack_out, 1'b1);
    end
    cin_d = 2'b00;
    @(negedge clk);
    chk("null_sum", bus8.sum, 8'h00);
    chk("null_cout", bus8.cout, 2'b00);
    chk("null_ack", bus8.ack_out, 1'b0);

    ack_d = 1'b0; drive(3, 5, 1'b0, 1'b1);
    @(negedge clk);
    chk("sub_sum", bus8.sum, 8'b10101001);
    chk("sub_cout", bus8.cout, 2'b01);
    chk("sub_cnt", bus8.wave_cnt, 8'd2);

    ack_d = 1'b1; drive_null();
    @(negedge clk);
    chk("null2_ack", bus8.ack_out, 1'b0);
    ack_d = 1'b0; drive(15, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("carry_sum", bus8.sum, 8'b01010101);
    chk("carry_cout", bus8.cout, 2'b10);
    chk("carry_cnt", bus8.wave_cnt, 8'd3);
    chk("w2_cnt3", bus2.wave_cnt, 2'd3);

    for (int k = 0; k < 2; k++) begin
      ack_d = 1'b1; drive_null();
      @(negedge clk);
      ack_d = 1'b0; drive(k, k, 1'b0, 1'b0);
      @(negedge clk);
      chk("wrap_cnt", bus2.wave_cnt, wrap_exp[k]);
    end

    ack_d = 1'b1; drive_null();
    @(negedge clk);
    ack_d = 1'b0; drive(6, 6, 1'b0, 1'b0); b_d[5:4] = 2'b11;
    @(negedge clk);
    chk("illegal_err", bus8.err, 1'b1);
    chk("illegal_ack", bus8.ack_out, 1'b0);
    drive(2, 2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("frozen_ack", bus8.ack_out, 1'b0);
    chk("frozen_cnt", bus8.wave_cnt, 8'd5);
    init_n = 1'b0;
    @(negedge clk);
    chk("clear_err", bus8.err, 1'b0);
    chk("clear_cnt", bus8.wave_cnt, 8'd0);
    init_n = 1'b1;
    @(negedge clk);
    chk("resume_sum", bus8.sum, 8'b01100101);
    chk("resume_ack", bus8.ack_out, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      init_n = ($urandom_range(0, 99) >= 2);
      ack_d  = ($urandom_range(0, 3) == 0) ? ~bus8.ack_out : bus8.ack_out;
      r = $urandom_range(0, 199);
      if (r < 160) begin
        if (bus8.ack_out) drive_null();
        else drive($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end else if (r < 175) begin
        drive($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end else if (r < 190) begin
        a_d[2*$urandom_range(0, 3) +: 2] = 2'b00;
        if ($urandom_range(0, 1) == 1) cin_d = 2'b00;
      end else if (r < 198) begin
        drive_null();
      end else begin
        b_d[2*$urandom_range(0, 3) +: 2] = 2'b11;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
